// File: rtl/s2mm_writer_pkg.sv
// Shared definitions for the stream-to-memory writer: FSM state encoding
// and the fixed AXI burst attributes used on the write address channel.
package s2mm_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } wr_state_e;

    localparam logic [2:0] AXI_SIZE_4B         = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR      = 2'b01;
    localparam int         AXI_RESP_SLVERR_BIT = 1;

endpackage

// File: rtl/s2mm_writer_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset. DEPTH must be a power
// of two; read data is the current head (first-word fall-through).
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy is unchanged when a push and a pop land in the same cycle.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/s2mm_writer.sv
// Stream-to-memory writer: buffers AXI-Stream beats and writes them out as
// fixed-length AXI INCR bursts into a circular buffer of 2^SM_log_length beats.
// Optional build macro S2MM_WRITER_ERR_EN adds a sticky SM_error output.
//
// state | meaning
// IDLE  | waiting for a full burst in the FIFO while enabled
// ADDR  | awvalid held, address stable until awready
// DATA  | streaming BURST_LEN beats from the FIFO head
// RESP  | bready held until the write response arrives
module s2mm_writer
    import s2mm_writer_pkg::*;
#(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int BURST_LEN     = 16
) (
    input  logic                     SYS_aclk,
    input  logic                     SYS_aresetn,
    input  logic                     S2MM_enable,
    input  logic [4:0]               SM_log_length,
    input  logic [MM_ADDR_WIDTH-1:0] SM_write_buffer,
    output logic                     SM_reading,
    output logic                     SM_writing,
    input  logic [31:0]              S_AXIS_tdata,
    input  logic                     S_AXIS_tvalid,
    output logic                     S_AXIS_tready,
    output logic [MM_ADDR_WIDTH-1:0] M_AXI_awaddr,
    output logic [7:0]               M_AXI_awlen,
    output logic [2:0]               M_AXI_awsize,
    output logic [1:0]               M_AXI_awburst,
    output logic                     M_AXI_awvalid,
    input  logic                     M_AXI_awready,
    output logic [31:0]              M_AXI_wdata,
    output logic [3:0]               M_AXI_wstrb,
    output logic                     M_AXI_wlast,
    output logic                     M_AXI_wvalid,
    input  logic                     M_AXI_wready,
    input  logic [1:0]               M_AXI_bresp,
    input  logic                     M_AXI_bvalid,
    output logic                     M_AXI_bready
`ifdef S2MM_WRITER_ERR_EN
    ,
    output logic                     SM_error
`endif
);

    localparam int FIFO_DEPTH = 2 * BURST_LEN;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    wr_state_e              state_q, state_d;
    logic [7:0]             beat_q, beat_d;
    logic [31:0]            offset_q, offset_d;
    logic [MM_ADDR_WIDTH-1:0] base_q, base_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [32:0]      offset_sum, buf_beats;
    logic [31:0]      offset_next;
    logic             last_beat;
    logic             unused_sig;

    assign S_AXIS_tready = SYS_aresetn & S2MM_enable & ~fifo_full;
    assign fifo_push     = S_AXIS_tvalid & S_AXIS_tready;
    assign SM_reading    = fifo_push;

    assign M_AXI_awvalid = (state_q == ST_ADDR);
    assign M_AXI_wvalid  = (state_q == ST_DATA);
    assign M_AXI_bready  = (state_q == ST_RESP);
    assign last_beat     = (beat_q == 8'(BURST_LEN - 1));
    assign M_AXI_wlast   = M_AXI_wvalid & last_beat;
    assign fifo_pop      = M_AXI_wvalid & M_AXI_wready;
    assign SM_writing    = fifo_pop;

    assign M_AXI_awlen   = 8'(BURST_LEN - 1);
    assign M_AXI_awsize  = AXI_SIZE_4B;
    assign M_AXI_awburst = AXI_BURST_INCR;
    assign M_AXI_wstrb   = 4'hF;
    assign M_AXI_awaddr  = base_q + MM_ADDR_WIDTH'({offset_q, 2'b00});

    // Wider sum so the wrap compare is exact even for 2^31-beat buffers.
    assign offset_sum  = {1'b0, offset_q} + 33'(BURST_LEN);
    assign buf_beats   = 33'd1 << SM_log_length;
    assign offset_next = (offset_sum >= buf_beats) ? 32'd0 : offset_sum[31:0];

    assign unused_sig  = ^{M_AXI_bresp, fifo_empty};

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (SYS_aclk),
        .rst_n_i (SYS_aresetn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (S_AXIS_tdata),
        .rdata_o (M_AXI_wdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state logic; the buffer base only tracks SM_write_buffer while idle
    // at a buffer start, so a base change never splits a buffer.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        offset_d = offset_q;
        base_d   = base_q;
        case (state_q)
            ST_IDLE: begin
                if (offset_q == '0) base_d = SM_write_buffer;
                if (S2MM_enable && (fifo_count >= CNT_W'(BURST_LEN))) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (M_AXI_awready) begin
                    state_d  = ST_DATA;
                    beat_d   = '0;
                    offset_d = offset_next;
                end
            end
            ST_DATA: begin
                if (M_AXI_wready) begin
                    beat_d = beat_q + 8'd1;
                    if (last_beat) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (M_AXI_bvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and address-tracking registers.
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            offset_q <= '0;
            base_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            offset_q <= offset_d;
            base_q   <= base_d;
        end
    end

`ifdef S2MM_WRITER_ERR_EN
    logic err_q, err_d;

    assign err_d    = err_q | (M_AXI_bvalid & M_AXI_bresp[AXI_RESP_SLVERR_BIT]);
    assign SM_error = err_q;

    // Sticky slave-error flag, cleared only by reset.
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) err_q <= 1'b0;
        else              err_q <= err_d;
    end
`endif

endmodule

// File: tb/tb_s2mm_writer.sv
module tb_s2mm_writer;

    localparam int BL = 16;

    logic        SYS_aclk = 1'b0;
    logic        SYS_aresetn = 1'b0;
    logic        S2MM_enable = 1'b0;
    logic [4:0]  SM_log_length = 5'd6;
    logic [31:0] SM_write_buffer = 32'h1000_0000;
    logic        SM_reading, SM_writing;
    logic [31:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tready;
    logic [31:0] M_AXI_awaddr;
    logic [7:0]  M_AXI_awlen;
    logic [2:0]  M_AXI_awsize;
    logic [1:0]  M_AXI_awburst;
    logic        M_AXI_awvalid;
    logic        M_AXI_awready = 1'b0;
    logic [31:0] M_AXI_wdata;
    logic [3:0]  M_AXI_wstrb;
    logic        M_AXI_wlast, M_AXI_wvalid;
    logic        M_AXI_wready = 1'b0;
    logic [1:0]  M_AXI_bresp = 2'b00;
    logic        M_AXI_bvalid = 1'b0;
    logic        M_AXI_bready;
`ifdef S2MM_WRITER_ERR_EN
    logic        SM_error;
`endif

    s2mm_writer #(.MM_ADDR_WIDTH(32), .BURST_LEN(BL)) dut (
        .SYS_aclk        (SYS_aclk),
        .SYS_aresetn     (SYS_aresetn),
        .S2MM_enable     (S2MM_enable),
        .SM_log_length   (SM_log_length),
        .SM_write_buffer (SM_write_buffer),
        .SM_reading      (SM_reading),
        .SM_writing      (SM_writing),
        .S_AXIS_tdata    (S_AXIS_tdata),
        .S_AXIS_tvalid   (S_AXIS_tvalid),
        .S_AXIS_tready   (S_AXIS_tready),
        .M_AXI_awaddr    (M_AXI_awaddr),
        .M_AXI_awlen     (M_AXI_awlen),
        .M_AXI_awsize    (M_AXI_awsize),
        .M_AXI_awburst   (M_AXI_awburst),
        .M_AXI_awvalid   (M_AXI_awvalid),
        .M_AXI_awready   (M_AXI_awready),
        .M_AXI_wdata     (M_AXI_wdata),
        .M_AXI_wstrb     (M_AXI_wstrb),
        .M_AXI_wlast     (M_AXI_wlast),
        .M_AXI_wvalid    (M_AXI_wvalid),
        .M_AXI_wready    (M_AXI_wready),
        .M_AXI_bresp     (M_AXI_bresp),
        .M_AXI_bvalid    (M_AXI_bvalid),
        .M_AXI_bready    (M_AXI_bready)
`ifdef S2MM_WRITER_ERR_EN
        ,
        .SM_error        (SM_error)
`endif
    );

    always #5 SYS_aclk = ~SYS_aclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder knobs set by the main sequence.
    int aw_delay = 0;
    int w_mode = 0;      // 0 always ready, 1 toggle, 2 random, 3 stalled
    int b_delay = 0;
    int err_burst = -1;
    int b_idx = 0;

    // AXI slave responder: drives awready/wready/bvalid just after each edge.
    initial begin
        int aw_wait = 0;
        int b_wait = 0;
        forever begin
            @(posedge SYS_aclk); #1;
            if (!SYS_aresetn) begin
                M_AXI_awready = 0; M_AXI_wready = 0; M_AXI_bvalid = 0; M_AXI_bresp = 0;
                aw_wait = 0; b_wait = 0;
            end else begin
                if (M_AXI_awvalid && !M_AXI_awready) begin
                    if (aw_wait >= aw_delay) M_AXI_awready = 1;
                    else aw_wait++;
                end else begin
                    M_AXI_awready = 0; aw_wait = 0;
                end
                case (w_mode)
                    0: M_AXI_wready = 1;
                    1: M_AXI_wready = ~M_AXI_wready;
                    2: M_AXI_wready = 1'($urandom_range(0, 1));
                    default: M_AXI_wready = 0;
                endcase
                if (M_AXI_bready) begin
                    if (!M_AXI_bvalid) begin
                        if (b_wait >= b_delay) begin
                            M_AXI_bvalid = 1;
                            M_AXI_bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
                            b_idx++;
                        end else b_wait++;
                    end
                end else begin
                    M_AXI_bvalid = 0; M_AXI_bresp = 0; b_wait = 0;
                end
            end
        end
    end

    // Reference model state: accepted-but-unwritten data, buffer position.
    logic [31:0] mq[$];
    logic [31:0] aw_log[$];
    logic [31:0] m_base = '0, aw_cand = '0, aw_prev = '0, wb_prev = '0;
    int m_off = 0, m_beat = 0;
    bit outstanding = 0, aw_was = 0, m_err = 0;
    int aw_count = 0, w_count = 0, b_count = 0, rd_count = 0, wlast_count = 0;

    always @(negedge SYS_aclk) begin
        bit exp_tready, exp_wvalid, exp_bready;
        if (!SYS_aresetn) begin
            mq.delete(); m_off = 0; m_beat = 0; outstanding = 0; aw_was = 0; m_err = 0;
        end else begin
            exp_tready = S2MM_enable && (mq.size() < 2 * BL);
            exp_wvalid = outstanding && (m_beat < BL);
            exp_bready = outstanding && (m_beat == BL);
            chk("tready", S_AXIS_tready, exp_tready);
            chk("sm_reading", SM_reading, S_AXIS_tvalid & exp_tready);
            chk("wvalid", M_AXI_wvalid, exp_wvalid);
            chk("sm_writing", SM_writing, exp_wvalid & M_AXI_wready);
            chk("bready", M_AXI_bready, exp_bready);
            chk("one_in_flight", M_AXI_awvalid & outstanding, 0);
            if (!exp_wvalid) chk("wlast_idle", M_AXI_wlast, 0);
            if (M_AXI_awvalid) begin
                if (aw_was) chk("awaddr_stable", M_AXI_awaddr, aw_prev);
                else aw_cand = wb_prev;
                if (M_AXI_awready) begin
                    if (m_off == 0) m_base = aw_cand;
                    chk("awaddr", M_AXI_awaddr, m_base + 32'(4 * m_off));
                    chk("awlen", M_AXI_awlen, BL - 1);
                    chk("awsize", M_AXI_awsize, 3'b010);
                    chk("awburst", M_AXI_awburst, 2'b01);
                    aw_log.push_back(M_AXI_awaddr);
                    aw_count++;
                    m_off = (m_off + BL) % (1 << SM_log_length);
                    outstanding = 1; m_beat = 0;
                end
            end
            if (M_AXI_wvalid && M_AXI_wready) begin
                if (mq.size() == 0) chk("w_underflow", 1, 0);
                else chk("wdata", M_AXI_wdata, mq.pop_front());
                chk("wlast", M_AXI_wlast, m_beat == BL - 1);
                chk("wstrb", M_AXI_wstrb, 4'hF);
                m_beat++; w_count++;
                if (M_AXI_wlast) wlast_count++;
            end
            if (M_AXI_bvalid && M_AXI_bready) begin
                outstanding = 0; b_count++;
            end
            if (S_AXIS_tvalid && S_AXIS_tready) begin
                mq.push_back(S_AXIS_tdata); rd_count++;
            end
`ifdef S2MM_WRITER_ERR_EN
            chk("sm_error", SM_error, m_err);
            if (M_AXI_bvalid && M_AXI_bresp[1]) m_err = 1;
`endif
            aw_was  = M_AXI_awvalid && !M_AXI_awready;
            aw_prev = M_AXI_awaddr;
        end
        wb_prev = SM_write_buffer;
    end

    task automatic step();
        @(posedge SYS_aclk); #1;
    endtask

    task automatic push_upto(input int n, input int budget, output int sent);
        bit acc;
        sent = 0;
        for (int c = 0; c < budget && sent < n; c++) begin
            if (!S_AXIS_tvalid) begin S_AXIS_tvalid = 1; S_AXIS_tdata = $urandom; end
            @(negedge SYS_aclk); acc = S_AXIS_tready;
            @(posedge SYS_aclk); #1;
            if (acc) begin sent++; S_AXIS_tvalid = 0; end
        end
        S_AXIS_tvalid = 0;
    endtask

    task automatic wait_b(input int target, input string tag);
        int c = 0;
        while (b_count < target && c < 3000) begin step(); c++; end
        chk(tag, 64'(b_count >= target), 1);
    endtask

    task automatic wait_aw(input int target, input string tag);
        int c = 0;
        while (aw_count < target && c < 3000) begin step(); c++; end
        chk(tag, 64'(aw_count >= target), 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int sent, rd0, w0, aw0, b0, wl0, c;
        bit acc;

        // Reset state
        repeat (3) step();
        chk("rst_awvalid", M_AXI_awvalid, 0);
        chk("rst_wvalid", M_AXI_wvalid, 0);
        chk("rst_wlast", M_AXI_wlast, 0);
        chk("rst_bready", M_AXI_bready, 0);
        chk("rst_tready", S_AXIS_tready, 0);
        chk("rst_reading", SM_reading, 0);
        chk("rst_writing", SM_writing, 0);
        SYS_aresetn = 1;
        step();
        chk("tready_disabled", S_AXIS_tready, 0);
        S2MM_enable = 1;
        #1;
        chk("tready_enabled", S_AXIS_tready, 1);

        // 64 continuous beats into a 64-beat buffer
        rd0 = rd_count; w0 = w_count; aw0 = aw_count; b0 = b_count;
        push_upto(64, 400, sent);
        chk("a_sent", sent, 64);
        wait_b(b0 + 4, "a_wait_b");
        chk("a_aw_count", aw_count - aw0, 4);
        chk("a_reading", rd_count - rd0, 64);
        chk("a_writing", w_count - w0, 64);
        for (int i = 0; i < 4; i++) chk("a_awaddr", aw_log[aw0 + i], 32'h1000_0000 + 32'(i * 'h40));

        // Buffer base changed mid-buffer takes effect at the next buffer only
        aw0 = aw_count; b0 = b_count;
        push_upto(16, 200, sent);
        wait_aw(aw0 + 1, "b_wait_aw");
        SM_write_buffer = 32'h1000_0100;
        push_upto(48, 400, sent);
        wait_b(b0 + 4, "b_wait_b4");
        for (int i = 0; i < 4; i++) chk("b_old_buf", aw_log[aw0 + i], 32'h1000_0000 + 32'(i * 'h40));
        push_upto(16, 200, sent);
        wait_b(b0 + 5, "b_wait_b5");
        chk("b_new_buf", aw_log[aw0 + 4], 32'h1000_0100);

        // Slow awready and toggling wready
        aw_delay = 5; w_mode = 1; b0 = b_count; wl0 = wlast_count;
        push_upto(16, 200, sent);
        wait_b(b0 + 1, "c_wait_b");
        chk("c_awaddr", aw_log[$], 32'h1000_0140);
        chk("c_wlast_count", wlast_count - wl0, 1);
        aw_delay = 0;

        // Back-pressure: wready held low, FIFO fills at 32
        w_mode = 3; b0 = b_count;
        push_upto(40, 120, sent);
        chk("d_accepted", sent, 32);
        S_AXIS_tvalid = 1;
        @(negedge SYS_aclk);
        chk("d_tready_full", S_AXIS_tready, 0);
        step();
        S_AXIS_tvalid = 0;
        w_mode = 0;
        push_upto(8, 200, sent);
        chk("d_resumed", sent, 8);
        wait_b(b0 + 2, "d_wait_b");

        // Reset in the middle of a data phase
        aw0 = aw_count;
        push_upto(8, 100, sent);
        c = 0;
        while (!(outstanding && m_beat == 7) && c < 500) begin step(); c++; end
        chk("e_reach_beat7", 64'(outstanding && m_beat == 7), 1);
        SYS_aresetn = 0;
        step();
        chk("e_wvalid", M_AXI_wvalid, 0);
        chk("e_awvalid", M_AXI_awvalid, 0);
        chk("e_bready", M_AXI_bready, 0);
        chk("e_writing", SM_writing, 0);
        SYS_aresetn = 1;
        aw0 = aw_count;
        push_upto(15, 100, sent);
        repeat (5) step();
        chk("e_fifo_empty_no_aw", aw_count - aw0, 0);
        b0 = b_count;
        push_upto(1, 20, sent);
        wait_b(b0 + 1, "e_wait_b");
        chk("e_aw_base", aw_log[$], 32'h1000_0100);

`ifdef S2MM_WRITER_ERR_EN
        // SLVERR on the second burst from here sets the sticky flag
        chk("f_err_clear", SM_error, 0);
        err_burst = b_idx + 1; b0 = b_count;
        push_upto(32, 200, sent);
        wait_b(b0 + 2, "f_wait_b");
        repeat (4) step();
        chk("f_err_sticky", SM_error, 1);
        SYS_aresetn = 0;
        step();
        SYS_aresetn = 1;
        chk("f_err_reset", SM_error, 0);
        err_burst = -1;
`endif

        // Randomised traffic with enable dropouts and random ready timing
        w_mode = 2; aw_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
        acc = 0;
        for (int i = 0; i < 1500; i++) begin
            if (!S_AXIS_tvalid || acc) begin
                S_AXIS_tvalid = ($urandom_range(0, 3) != 0);
                S_AXIS_tdata = $urandom;
            end
            S2MM_enable = ($urandom_range(0, 15) != 0);
            @(negedge SYS_aclk); acc = S_AXIS_tvalid && S_AXIS_tready;
            step();
        end
        S_AXIS_tvalid = 0;
        S2MM_enable = 1;
        c = 0;
        while ((outstanding || mq.size() >= BL) && c < 2000) begin step(); c++; end
        chk("g_drained", 64'(outstanding || mq.size() >= BL), 0);
        #1;
        chk("g_tready_final", S_AXIS_tready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
